// File: rtl/video_timing_pkg.sv
// Video timing package: mode descriptor struct, standard CEA/VESA modes,
// mode-switch state encoding and (with VIDEO_TIMING_GEN_PATTERN_EN) the
// colour-bar palette.
package video_timing_pkg;

    localparam int VT_FIELD_W = 12;

    typedef struct packed {
        logic [VT_FIELD_W-1:0] HSYNC;
        logic [VT_FIELD_W-1:0] HBACK;
        logic [VT_FIELD_W-1:0] HACTIVE;
        logic [VT_FIELD_W-1:0] HFRONT;
        logic [VT_FIELD_W-1:0] VSYNC;
        logic [VT_FIELD_W-1:0] VBACK;
        logic [VT_FIELD_W-1:0] VACTIVE;
        logic [VT_FIELD_W-1:0] VFRONT;
        logic                  hpol;
        logic                  vpol;
    } video_timing_t;

    localparam video_timing_t VT_720P60 = '{
        HSYNC: 12'd40, HBACK: 12'd220, HACTIVE: 12'd1280, HFRONT: 12'd110,
        VSYNC: 12'd5,  VBACK: 12'd20,  VACTIVE: 12'd720,  VFRONT: 12'd5,
        hpol: 1'b1, vpol: 1'b1
    };

    localparam video_timing_t VT_1080P60 = '{
        HSYNC: 12'd44, HBACK: 12'd148, HACTIVE: 12'd1920, HFRONT: 12'd88,
        VSYNC: 12'd5,  VBACK: 12'd36,  VACTIVE: 12'd1080, VFRONT: 12'd4,
        hpol: 1'b1, vpol: 1'b1
    };

    localparam video_timing_t VT_1600X1200P60 = '{
        HSYNC: 12'd192, HBACK: 12'd304, HACTIVE: 12'd1600, HFRONT: 12'd64,
        VSYNC: 12'd3,   VBACK: 12'd46,  VACTIVE: 12'd1200, VFRONT: 12'd1,
        hpol: 1'b1, vpol: 1'b1
    };

    // Mode-switch tracker: steady, or holding a mode to apply at frame end.
    typedef enum logic {
        MS_STEADY,
        MS_PENDING
    } mode_state_e;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        c = 24'h000000;
        case (idx)
            3'd0: c = 24'hFFFFFF;
            3'd1: c = 24'hFFFF00;
            3'd2: c = 24'h00FFFF;
            3'd3: c = 24'h00FF00;
            3'd4: c = 24'hFF00FF;
            3'd5: c = 24'hFF0000;
            3'd6: c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction
`endif

endpackage

// File: rtl/video_timing_gen_if.sv
// Video timing bus: mode request/report plus registered raster outputs.
// video_data exists only when VIDEO_TIMING_GEN_PATTERN_EN is defined.
interface video_timing_gen_if #(
    parameter int COORD_WIDTH = 12,
    parameter int MODE_WIDTH  = 2
);
    logic [MODE_WIDTH-1:0]  mode_sel;
    logic [MODE_WIDTH-1:0]  mode_active;
    logic                   video_de;
    logic                   video_hsync;
    logic                   video_vsync;
    logic [COORD_WIDTH-1:0] video_x;
    logic [COORD_WIDTH-1:0] video_y;
    logic                   frame_start;
    logic                   line_start;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    logic [23:0]            video_data;

    modport master (
        input  mode_sel,
        output mode_active, video_de, video_hsync, video_vsync,
        output video_x, video_y, frame_start, line_start, video_data
    );

    modport slave (
        output mode_sel,
        input  mode_active, video_de, video_hsync, video_vsync,
        input  video_x, video_y, frame_start, line_start, video_data
    );
`else
    modport master (
        input  mode_sel,
        output mode_active, video_de, video_hsync, video_vsync,
        output video_x, video_y, frame_start, line_start
    );

    modport slave (
        output mode_sel,
        input  mode_active, video_de, video_hsync, video_vsync,
        input  video_x, video_y, frame_start, line_start
    );
`endif
endinterface

// File: rtl/video_timing_gen_axis_counter.sv
// One raster axis: counter over sync, back porch, active, front porch,
// with combinational region decode of the current count.
module video_axis_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    input  logic [WIDTH-1:0] sync_len,
    input  logic [WIDTH-1:0] back_len,
    input  logic [WIDTH-1:0] active_len,
    input  logic [WIDTH-1:0] front_len,
    output logic [WIDTH-1:0] count,
    output logic             at_end,
    output logic             in_sync,
    output logic             in_active,
    output logic [WIDTH-1:0] coord
);
    logic [WIDTH-1:0] act_start;
    logic [WIDTH-1:0] last;

    assign act_start = sync_len + back_len;
    assign last      = sync_len + back_len + active_len + front_len - WIDTH'(1);

    // Position counter: steps on advance, wraps after the front porch.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (advance) begin
            count <= at_end ? '0 : count + WIDTH'(1);
        end
    end

    // Region decode of the current position.
    always_comb begin
        at_end    = (count == last);
        in_sync   = (count < sync_len);
        in_active = (count >= act_start) && (count < act_start + active_len);
        coord     = in_active ? count - act_start : '0;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode video timing generator. Mode changes are deferred to the
// frame boundary. Optional colour-bar source on video_data when
// VIDEO_TIMING_GEN_PATTERN_EN is defined.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int NUM_MODES   = 3,
    parameter int COORD_WIDTH = 12,
    parameter video_timing_t [NUM_MODES-1:0] MODES =
        {VT_1600X1200P60, VT_1080P60, VT_720P60},
    parameter int INIT_MODE   = 0
) (
    input logic                clock,
    input logic                reset,
    video_timing_gen_if.master vid
);
    localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam logic [MODE_W-1:0] INIT_SEL = MODE_W'(INIT_MODE);
    localparam video_timing_t INIT_CFG = MODES[INIT_MODE];

    mode_state_e            ms, ms_next;
    logic [MODE_W-1:0]      cur_mode, mode_next;
    logic [MODE_W-1:0]      pend_mode, pend_next;
    video_timing_t          cfg;
    logic                   sel_valid;
    logic                   frame_wrap;
    logic                   de_now;
    logic [COORD_WIDTH-1:0] h_count, v_count, h_coord, v_coord;
    logic                   h_end, v_end, h_sync, v_sync, h_act, v_act;

    assign cfg        = MODES[cur_mode];
    assign frame_wrap = h_end & v_end;
    assign sel_valid  = (int'(vid.mode_sel) < NUM_MODES);
    assign de_now     = h_act & v_act;

    video_axis_counter #(.WIDTH(COORD_WIDTH)) u_h_axis (
        .clock      (clock),
        .reset      (reset),
        .advance    (1'b1),
        .sync_len   (COORD_WIDTH'(cfg.HSYNC)),
        .back_len   (COORD_WIDTH'(cfg.HBACK)),
        .active_len (COORD_WIDTH'(cfg.HACTIVE)),
        .front_len  (COORD_WIDTH'(cfg.HFRONT)),
        .count      (h_count),
        .at_end     (h_end),
        .in_sync    (h_sync),
        .in_active  (h_act),
        .coord      (h_coord)
    );

    video_axis_counter #(.WIDTH(COORD_WIDTH)) u_v_axis (
        .clock      (clock),
        .reset      (reset),
        .advance    (h_end),
        .sync_len   (COORD_WIDTH'(cfg.VSYNC)),
        .back_len   (COORD_WIDTH'(cfg.VBACK)),
        .active_len (COORD_WIDTH'(cfg.VACTIVE)),
        .front_len  (COORD_WIDTH'(cfg.VFRONT)),
        .count      (v_count),
        .at_end     (v_end),
        .in_sync    (v_sync),
        .in_active  (v_act),
        .coord      (v_coord)
    );

    // Mode-switch state, current mode and pending mode registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ms        <= MS_STEADY;
            cur_mode  <= INIT_SEL;
            pend_mode <= INIT_SEL;
        end else begin
            ms        <= ms_next;
            cur_mode  <= mode_next;
            pend_mode <= pend_next;
        end
    end

    // Apply a held mode at the frame wrap, then re-evaluate mode_sel against
    // the mode that will be in force next cycle, so a request arriving on
    // the wrap cycle itself waits for the following frame boundary.
    always_comb begin
        ms_next   = ms;
        mode_next = cur_mode;
        pend_next = pend_mode;
        if (ms == MS_PENDING && frame_wrap) begin
            mode_next = pend_mode;
            ms_next   = MS_STEADY;
        end
        if (sel_valid) begin
            if (vid.mode_sel != mode_next) begin
                ms_next   = MS_PENDING;
                pend_next = vid.mode_sel;
            end else begin
                ms_next   = MS_STEADY;
            end
        end
    end

    // Registered raster outputs, one cycle behind the counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            vid.mode_active <= INIT_SEL;
            vid.video_de    <= 1'b0;
            vid.video_hsync <= ~INIT_CFG.hpol;
            vid.video_vsync <= ~INIT_CFG.vpol;
            vid.video_x     <= '0;
            vid.video_y     <= '0;
            vid.frame_start <= 1'b0;
            vid.line_start  <= 1'b0;
        end else begin
            vid.mode_active <= cur_mode;
            vid.video_de    <= de_now;
            vid.video_hsync <= h_sync ^ ~cfg.hpol;
            vid.video_vsync <= v_sync ^ ~cfg.vpol;
            vid.video_x     <= de_now ? h_coord : '0;
            vid.video_y     <= de_now ? v_coord : '0;
            vid.frame_start <= (h_count == '0) && (v_count == '0);
            vid.line_start  <= (h_count == '0);
        end
    end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    logic [COORD_WIDTH-1:0] bar_w;
    logic [COORD_WIDTH-1:0] bar_pos;
    logic [2:0]             bar_idx;

    assign bar_w = COORD_WIDTH'(cfg.HACTIVE) >> 3;

    // Bar tracker; values describe the current h, cleared outside the
    // active span so each line restarts at bar 0. Bar 7 absorbs the rest.
    always_ff @(posedge clock) begin
        if (reset || !h_act) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (bar_idx != 3'd7 && bar_pos == bar_w - COORD_WIDTH'(1)) begin
            bar_pos <= '0;
            bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_pos <= bar_pos + COORD_WIDTH'(1);
        end
    end

    // Registered pixel colour, aligned with video_de.
    always_ff @(posedge clock) begin
        if (reset) begin
            vid.video_data <= '0;
        end else begin
            vid.video_data <= de_now ? bar_colour(bar_idx) : '0;
        end
    end
`endif

endmodule
